// File: rtl/sipo_frame_unpacker.sv
// Latches a parallel frame, shifts it out one bit per clock and reassembles the
// serial stream into NUM_WORDS words of WORD_W bits with per-word strobes.
module sipo_frame_unpacker #(
    parameter int FRAME_W   = 32,
    parameter int WORD_W    = 5,
    parameter int NUM_WORDS = 5,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [FRAME_W-1:0]            DATA,
    output logic                          busy,
    output logic                          ser_out,
    output logic                          ser_valid,
    output logic                          word_valid,
    output logic [IDX_W-1:0]              word_idx,
    output logic [NUM_WORDS*WORD_W-1:0]   out_words,
    output logic                          finished,
    output logic [1:0]                    dbg_state
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(NUM_WORDS - 1);

    generate
        if (NUM_WORDS * WORD_W > FRAME_W || WORD_W < 1 || NUM_WORDS < 1) begin : g_bad_cfg
            $error("sipo_frame_unpacker: NUM_WORDS*WORD_W must not exceed FRAME_W");
        end
    endgenerate

    // Handshake: start is accepted on a rising edge only when busy=0; DATA is
    // sampled on that edge alone. ser_out is meaningful exactly while ser_valid=1.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                        r_state;
    logic [FRAME_W-1:0]            r_sr;
    logic [WORD_W-1:0]             r_word;
    logic [BIT_W-1:0]              r_bit_cnt;
    logic [IDX_W-1:0]              r_word_cnt;
    logic [NUM_WORDS*WORD_W-1:0]   r_out_words;
    logic                          r_word_valid;
    logic [IDX_W-1:0]              r_word_idx;
    logic                          r_finished;

    logic                          w_bit;
    logic [WORD_W-1:0]             w_word_next;

    assign w_bit = MSB_FIRST ? r_sr[FRAME_W-1] : r_sr[0];

    // First bit of each word lands in the MSB (MSB_FIRST) or the LSB otherwise.
    always_comb begin
        w_word_next = '0;
        if (MSB_FIRST) begin
            w_word_next = (r_word << 1) | WORD_W'(w_bit);
        end else begin
            w_word_next = (r_word >> 1) | (WORD_W'(w_bit) << (WORD_W - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_word       <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_out_words  <= '0;
            r_word_valid <= 1'b0;
            r_word_idx   <= '0;
            r_finished   <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sr        <= DATA;
                        r_word      <= '0;
                        r_bit_cnt   <= '0;
                        r_word_cnt  <= '0;
                        r_out_words <= '0;
                        r_finished  <= 1'b0;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr   <= MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
                    r_word <= w_word_next;
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
                        r_out_words[r_word_cnt*WORD_W +: WORD_W] <= w_word_next;
                        r_word_valid <= 1'b1;
                        r_word_idx   <= r_word_cnt;
                        if (r_word_cnt == WORD_LAST) begin
                            r_state    <= S_DONE;
                            r_finished <= 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state == S_SHIFT);
    assign ser_valid  = busy;
    assign ser_out    = busy ? w_bit : 1'b0;
    assign word_valid = r_word_valid;
    assign word_idx   = r_word_idx;
    assign out_words  = r_out_words;
    assign finished   = r_finished;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sipo_frame_unpacker.sv
// Bench for sipo_frame_unpacker: three configurations share start/DATA and are
// checked every cycle against an arithmetic model of the frame-to-word mapping.
module tb_sipo_frame_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_in = '0;

  // A: 32/5x5 MSB first, B: 32/5x5 LSB first, C: 16/4x4 MSB first
  logic a_busy, a_ser, a_sv, a_wv, a_fin;
  logic [2:0] a_idx;
  logic [24:0] a_words;
  logic [1:0] a_state;
  logic b_busy, b_ser, b_sv, b_wv, b_fin;
  logic [2:0] b_idx;
  logic [24:0] b_words;
  logic [1:0] b_state;
  logic c_busy, c_ser, c_sv, c_wv, c_fin;
  logic [1:0] c_idx;
  logic [15:0] c_words;
  logic [1:0] c_state;

  sipo_frame_unpacker #(.FRAME_W(32), .WORD_W(5), .NUM_WORDS(5), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(start), .DATA(data_in),
    .busy(a_busy), .ser_out(a_ser), .ser_valid(a_sv), .word_valid(a_wv),
    .word_idx(a_idx), .out_words(a_words), .finished(a_fin), .dbg_state(a_state));

  sipo_frame_unpacker #(.FRAME_W(32), .WORD_W(5), .NUM_WORDS(5), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start), .DATA(data_in),
    .busy(b_busy), .ser_out(b_ser), .ser_valid(b_sv), .word_valid(b_wv),
    .word_idx(b_idx), .out_words(b_words), .finished(b_fin), .dbg_state(b_state));

  sipo_frame_unpacker #(.FRAME_W(16), .WORD_W(4), .NUM_WORDS(4), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .start(start), .DATA(data_in[15:0]),
    .busy(c_busy), .ser_out(c_ser), .ser_valid(c_sv), .word_valid(c_wv),
    .word_idx(c_idx), .out_words(c_words), .finished(c_fin), .dbg_state(c_state));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard types ----------------
  typedef struct packed {
    logic        busy;
    logic        sv;
    logic        ser;
    logic        wv;
    logic [2:0]  widx;
    logic        fin;
    logic [31:0] words;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    logic [24:0] a_w;
    logic [24:0] b_w;
    logic [15:0] c_w;
  } vec_t;

  vec_t vecs[4];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // j = number of rising edges since the start-accept edge.
  function automatic obs_t model(input int fw, input int w, input int nw, input bit msb,
                                 input logic [31:0] d, input int j);
    obs_t o;
    int n;
    logic [31:0] mask;
    logic [31:0] wk;
    o = '0;
    n = nw * w;
    mask = (32'd1 << w) - 32'd1;
    if (j < n) begin
      o.busy = 1'b1;
      o.sv   = 1'b1;
      o.ser  = msb ? d[fw-1-j] : d[j];
    end else begin
      o.fin = 1'b1;
    end
    if (j >= 1 && j <= n && (j % w) == 0) begin
      o.wv   = 1'b1;
      o.widx = 3'(j / w - 1);
    end
    for (int k = 0; k < nw; k++) begin
      if ((k + 1) * w <= j) begin
        wk = msb ? ((d >> (fw - (k + 1) * w)) & mask) : ((d >> (k * w)) & mask);
        o.words = o.words | (wk << (k * w));
      end
    end
    return o;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o = '{a_busy, a_sv, a_ser, a_wv, (a_wv ? a_idx : 3'd0), a_fin, {7'd0, a_words}};
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o = '{b_busy, b_sv, b_ser, b_wv, (b_wv ? b_idx : 3'd0), b_fin, {7'd0, b_words}};
    return o;
  endfunction

  function automatic obs_t obs_c();
    obs_t o;
    o = '{c_busy, c_sv, c_ser, c_wv, (c_wv ? {1'b0, c_idx} : 3'd0), c_fin, {16'd0, c_words}};
    return o;
  endfunction

  // ---------------- checkers ----------------
  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got busy=%b sv=%b ser=%b wv=%b idx=%0d fin=%b words=%h, expected busy=%b sv=%b ser=%b wv=%b idx=%0d fin=%b words=%h",
                  name, act.busy, act.sv, act.ser, act.wv, act.widx, act.fin, act.words,
                  exp.busy, exp.sv, exp.ser, exp.wv, exp.widx, exp.fin, exp.words);
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check_obs({tag, " A"}, obs_a(), '0);
    check_obs({tag, " B"}, obs_b(), '0);
    check_obs({tag, " C"}, obs_c(), '0);
    check_val({tag, " A idx"}, {29'd0, a_idx}, 32'd0);
    check_val({tag, " C idx"}, {30'd0, c_idx}, 32'd0);
    check_val({tag, " A state"}, {30'd0, a_state}, 32'd0);
    check_val({tag, " B state"}, {30'd0, b_state}, 32'd0);
    check_val({tag, " C state"}, {30'd0, c_state}, 32'd0);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge. glitch_at: cycle to pulse start with other
  // DATA while busy (-1 = none); rst_at: cycle to assert reset (-1 = none).
  task automatic run_frame(input logic [31:0] d, input int glitch_at, input int rst_at,
                           input int tail);
    start   = 1'b1;
    data_in = d;
    for (int j = 0; j <= 25 + tail; j++) begin
      @(negedge clk);
      start   = 1'b0;
      data_in = $urandom;
      if (rst_at >= 0 && j == rst_at + 1) begin
        rst = 1'b0;
        check_reset_state($sformatf("midrst j=%0d", j));
        return;
      end
      check_obs($sformatf("A j=%0d", j), obs_a(), model(32, 5, 5, 1'b1, d, j));
      check_obs($sformatf("B j=%0d", j), obs_b(), model(32, 5, 5, 1'b0, d, j));
      check_obs($sformatf("C j=%0d", j), obs_c(), model(16, 4, 4, 1'b1, d & 32'hFFFF, j));
      if (j == glitch_at) begin
        start   = 1'b1;
        data_in = ~d;
      end
      if (j == rst_at) rst = 1'b1;
    end
  endtask

  task automatic frame_vec(input int i, input int glitch_at, input int tail);
    run_frame(vecs[i].data, glitch_at, -1, tail);
    check_val($sformatf("vec%0d A words", i), {7'd0, a_words}, {7'd0, vecs[i].a_w});
    check_val($sformatf("vec%0d B words", i), {7'd0, b_words}, {7'd0, vecs[i].b_w});
    check_val($sformatf("vec%0d C words", i), {16'd0, c_words}, {16'd0, vecs[i].c_w});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // expected slots written as {slot_last, ..., slot0}
    vecs[0] = '{32'h21808218, {5'd4, 5'd8, 5'd0, 5'd6, 5'd4},
                              {5'd24, 5'd1, 5'd0, 5'd16, 5'd24},
                              {4'd8, 4'd1, 4'd2, 4'd8}};
    vecs[1] = '{32'h0000A5C3, {5'd11, 5'd10, 5'd0, 5'd0, 5'd0},
                              {5'd0, 5'd1, 5'd9, 5'd14, 5'd3},
                              {4'h3, 4'hC, 4'h5, 4'hA}};
    vecs[2] = '{32'hFFFFFFFF, {5{5'h1F}}, {5{5'h1F}}, 16'hFFFF};
    vecs[3] = '{32'h00000000, 25'd0, 25'd0, 16'd0};

    // reset held for 3 cycles, with start asserted to show reset wins
    rst = 1'b1;
    start = 1'b1;
    data_in = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check_reset_state("rst held");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_reset_state("after rst");

    // table-driven frames, back-to-back from DONE
    for (int i = 0; i < 4; i++) frame_vec(i, -1, $urandom_range(0, 2));

    // start pulsed while busy at bit 10: ignored
    frame_vec(0, 10, 0);

    // reset mid-frame at bit 12, then all-ones frame from IDLE
    run_frame(vecs[1].data, -1, 12, 0);
    frame_vec(2, -1, 0);

    // restart from DONE with zero data
    frame_vec(3, -1, 1);

    // randomized frames against the model
    for (int r = 0; r < 10; r++) begin
      run_frame($urandom, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : -1, -1,
                $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
